mw_writeback_stage: RTL

- Final (memory→writeback) pipeline stage of the core; sits directly upstream of the register file.
- Accepts one retiring instruction per cycle from the memory stage and waits for the load response when needed.
- Presents each result to the register file for exactly one cycle, as W_result plus the MW_insn_* write-select fields.
- Stalls the memory stage while a load is outstanding.

---
 rtl/mw_writeback_stage_pkg.sv | 15 +
 rtl/mw_writeback_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mw_writeback_stage_pkg.sv
// Shared types and default widths for the memory->writeback stage.
package mw_writeback_stage_pkg;

  // Default widths of register data and register indices.
  localparam int unsigned MW_DATA_W = 8;
  localparam int unsigned MW_PTR_W  = 4;

  // Stage state: nothing to present, presenting a result, or waiting on load data.
  typedef enum logic [1:0] {
    MW_ST_EMPTY    = 2'd0,
    MW_ST_COMMIT   = 2'd1,
    MW_ST_WAIT_MEM = 2'd2
  } mw_state_e;

endpackage

// File: rtl/mw_writeback_stage.sv
// Final pipeline stage: retires one instruction per cycle toward the register
// file, stalling the memory stage while a load response is outstanding.
module mw_writeback_stage
  import mw_writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_W = MW_DATA_W,
  parameter int unsigned PTR_W  = MW_PTR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              XM_valid,
  output logic              XM_ready,
  input  logic [PTR_W-1:0]  XM_insn_dst,
  input  logic [PTR_W-1:0]  XM_insn_src_0,
  input  logic              XM_insn_is_F1,
  input  logic              XM_insn_is_F2,
  input  logic              XM_insn_is_load,
  input  logic [DATA_W-1:0] XM_alu_result,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [DATA_W-1:0] W_result,
  output logic [PTR_W-1:0]  MW_insn_dst,
  output logic [PTR_W-1:0]  MW_insn_src_0,
  output logic              MW_insn_is_F1,
  output logic              MW_insn_is_F2,
  output logic              MW_retire,
  output logic              err_unexpected_rsp
);

  mw_state_e state, state_next;

  // Fields of a load waiting for its data; kept apart from the presented
  // fields so the register-file outputs hold their last values while waiting.
  logic [PTR_W-1:0]  pend_dst;
  logic [PTR_W-1:0]  pend_src_0;
  logic              pend_f1;
  logic              pend_f2;

  // Fields presented to the register file; they change only on entry to COMMIT.
  logic [DATA_W-1:0] res_q;
  logic [PTR_W-1:0]  dst_q;
  logic [PTR_W-1:0]  src_0_q;
  logic              f1_q;
  logic              f2_q;
  logic              err_q;

  logic xfer;
  logic rsp_accept;

  assign XM_ready   = (state != MW_ST_WAIT_MEM);
  assign xfer       = XM_valid & XM_ready;
  assign rsp_accept = mem_rsp_valid & (state == MW_ST_WAIT_MEM);

  // Next-state logic for the EMPTY / COMMIT / WAIT_MEM sequencer.
  always_comb begin
    // NOTE: default assigned first so every path drives state_next (no latch).
    state_next = state;
    unique case (state)
      MW_ST_EMPTY, MW_ST_COMMIT: begin
        if (xfer) state_next = XM_insn_is_load ? MW_ST_WAIT_MEM : MW_ST_COMMIT;
        else      state_next = MW_ST_EMPTY;
      end
      MW_ST_WAIT_MEM: begin
        if (mem_rsp_valid) state_next = MW_ST_COMMIT;
      end
      default: state_next = MW_ST_EMPTY;
    endcase
  end

  // State register; an outstanding load is simply dropped by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments for all clocked state.
    if (!reset_n) state <= MW_ST_EMPTY;
    else          state <= state_next;
  end

  // Capture the write-select fields of an accepted load until its data arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_dst   <= '0;
      pend_src_0 <= '0;
      pend_f1    <= 1'b0;
      pend_f2    <= 1'b0;
    end else if (xfer && XM_insn_is_load) begin
      pend_dst   <= XM_insn_dst;
      pend_src_0 <= XM_insn_src_0;
      pend_f1    <= XM_insn_is_F1;
      pend_f2    <= XM_insn_is_F2;
    end
  end

  // Load the presented result: directly for ALU ops, from the pending load on response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q   <= '0;
      dst_q   <= '0;
      src_0_q <= '0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
    end else if (xfer && !XM_insn_is_load) begin
      res_q   <= XM_alu_result;
      dst_q   <= XM_insn_dst;
      src_0_q <= XM_insn_src_0;
      f1_q    <= XM_insn_is_F1;
      f2_q    <= XM_insn_is_F2;
    end else if (rsp_accept) begin
      res_q   <= mem_rsp_data;
      dst_q   <= pend_dst;
      src_0_q <= pend_src_0;
      f1_q    <= pend_f1;
      f2_q    <= pend_f2;
    end
  end

  // Sticky flag for a response that arrives with no load outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    err_q <= 1'b0;
    else if (mem_rsp_valid && state != MW_ST_WAIT_MEM) err_q <= 1'b1;
  end

  assign W_result           = res_q;
  assign MW_insn_dst        = dst_q;
  assign MW_insn_src_0      = src_0_q;
  assign MW_retire          = (state == MW_ST_COMMIT);
  assign MW_insn_is_F1      = MW_retire & f1_q;
  assign MW_insn_is_F2      = MW_retire & f2_q;
  assign err_unexpected_rsp = err_q;

endmodule
